vga_draw_arbiter: RTL

- Shares the single VGA adapter plot port (x, y, colour, plot) among the game's pixel drawers: full-screen picture drawer, brick drawer, ball drawer, paddle drawer.
- Round-robin arbitration with a held grant: a winner owns the port until it pulses done, or until a watchdog expires.
- Optionally aligns new grants to the frame tick.
- Sits between the drawers and the VGA adapter instance in the top level.

---
 rtl/vga_draw_arbiter_pkg.sv | 22 ++
 rtl/vga_draw_arbiter_rr_pick.sv | 33 +++
 rtl/vga_draw_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/vga_draw_arbiter_pkg.sv
// Shared constants and FSM encoding for the VGA plot-port arbiter.
// Screen geometry matches the 160x120, 3-bit-colour adapter mode.
package vga_draw_arbiter_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int PIX_COUNT = SCREEN_W * SCREEN_H;
  localparam int COORD_W   = 10;
  localparam int COLOUR_W  = 3;

  localparam int REQ_PIC    = 0;
  localparam int REQ_BRICK  = 1;
  localparam int REQ_BALL   = 2;
  localparam int REQ_PADDLE = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/vga_draw_arbiter_rr_pick.sv
// Combinational round-robin search: the first set request bit found
// walking upward (with wrap) from ptr+1, returned one-hot and as an index.
module vga_draw_arbiter_rr_pick #(
  parameter int  N_REQ = 4,
  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [PW-1:0]    idx,
  output logic             valid
);

  int cand;

  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no path leaves a value unassigned and no latch appears.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        onehot[cand] = 1'b1;
        idx          = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Shares the VGA adapter plot port among the game's drawers with a held,
// round-robin grant, optional frame alignment and a release watchdog.
module vga_draw_arbiter
  import vga_draw_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int FRAME_GATE = 1,
  parameter int TIMEOUT    = 32768,
  parameter int TW         = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      frame,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          done,
  input  logic [N_REQ-1:0]          plot_in,
  input  logic [COORD_W*N_REQ-1:0]  x_in,
  input  logic [COORD_W*N_REQ-1:0]  y_in,
  input  logic [COLOUR_W*N_REQ-1:0] colour_in,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic [COORD_W-1:0]        vga_x,
  output logic [COORD_W-1:0]        vga_y,
  output logic [COLOUR_W-1:0]       vga_colour,
  output logic                      vga_plot,
  output logic                      timeout_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t          state, state_nxt;
  logic [PW-1:0]       rr_ptr;
  logic                frame_pend;
  logic [TW-1:0]       watchdog;

  logic [N_REQ-1:0]    pick_onehot;
  logic [PW-1:0]       pick_idx;
  logic                pick_valid;

  logic                pend_eff;
  logic                issue;
  logic                expire;
  logic                release_g;
  logic [COORD_W-1:0]  cur_x;
  logic [COORD_W-1:0]  cur_y;
  logic [COLOUR_W-1:0] cur_colour;

  vga_draw_arbiter_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // While a grant is held, rr_ptr is the granted index.
  assign cur_x      = x_in[int'(rr_ptr)*COORD_W +: COORD_W];
  assign cur_y      = y_in[int'(rr_ptr)*COORD_W +: COORD_W];
  assign cur_colour = colour_in[int'(rr_ptr)*COLOUR_W +: COLOUR_W];

  assign pend_eff  = (FRAME_GATE == 0) ? 1'b1 : frame_pend;
  assign issue     = (state == ST_IDLE) && pick_valid && pend_eff;
  assign expire    = (state == ST_OWN) && (watchdog == TW'(TIMEOUT - 1));
  assign release_g = (state == ST_OWN) && (done[rr_ptr] || expire);

  // NOTE: this codebase resets synchronously, so resetn is sampled only at
  // clk edges and does not appear in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (issue) state_nxt = ST_OWN;
      ST_OWN:  if (release_g) state_nxt = ST_GAP;
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      grant       <= '0;
      busy        <= 1'b0;
      rr_ptr      <= PW'(N_REQ - 1);
      frame_pend  <= 1'b0;
      watchdog    <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
      vga_plot    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // A frame in the grant cycle wins, so that tick is not lost.
      if (frame)      frame_pend <= 1'b1;
      else if (issue) frame_pend <= 1'b0;

      vga_plot <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            grant    <= pick_onehot;
            busy     <= 1'b1;
            rr_ptr   <= pick_idx;
            watchdog <= '0;
          end
        end
        ST_OWN: begin
          watchdog   <= watchdog + TW'(1);
          vga_x      <= cur_x;
          vga_y      <= cur_y;
          vga_colour <= cur_colour;
          // The pixel that accompanies done is still written out.
          vga_plot   <= plot_in[rr_ptr];
          if (release_g) begin
            grant <= '0;
            busy  <= 1'b0;
          end
          if (expire) timeout_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
